hazard_stall_ctrl: RTL

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

---
 rtl/hazard_pkg.sv | 14 +
 rtl/sat_counter.sv | 38 +++
 rtl/hazard_stall_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard / stall controller.
//   state_e         : controller FSM state (RUN while the pipeline flows,
//                     MEM_WAIT while a data-cache miss is outstanding)
//   CNT_W_DEFAULT   : default width of the saturating performance counters
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_e;

    localparam int CNT_W_DEFAULT = 16;

endpackage : hazard_pkg

// File: rtl/sat_counter.sv
// Saturating up-counter used for pipeline performance statistics.
// Ports:
//   clk_i  : clock, counts on the rising edge
//   rst_i  : asynchronous active-low reset, clears the count
//   inc_i  : add one this cycle (ignored once the count is all-ones)
//   cnt_o  : current count
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge value of its inputs regardless of block ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule : sat_counter

// File: rtl/hazard_stall_ctrl.sv
// Pipeline hazard / stall controller.
// Detects data-cache misses (freezes the whole pipeline until the cache
// acknowledges), load-use hazards (stalls IF/ID and bubbles ID_EX) and taken
// branches (flushes IF_ID). Priority is freeze > load-use > branch flush.
// Ports:
//   clk_i, rst_i                  : clock, async active-low reset
//   IF_ID_RS1addr_i/RS2addr_i     : source registers of the instruction in ID
//   ID_EX_RDaddr_i/MemRead_i      : destination / load flag of the instruction in EX
//   EX_MEM_MemRead_i/MemWrite_i   : instruction in MEM accesses data memory
//   mem_stall_i, mem_ack_i        : data-cache busy / access-complete handshake
//   Branch_taken_i                : branch resolved taken in ID
//   PCWrite_o, IF_ID_Write_o      : PC / IF_ID update enables
//   IF_ID_Flush_o, ID_EX_Flush_o  : bubble insertion
//   Freeze_o                      : hold every pipeline register
//   stall_cnt_o, flush_cnt_o      : saturating stall / flush cycle counts
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       IF_ID_RS1addr_i,
    input  logic [4:0]       IF_ID_RS2addr_i,
    input  logic [4:0]       ID_EX_RDaddr_i,
    input  logic             ID_EX_MemRead_i,
    input  logic             EX_MEM_MemRead_i,
    input  logic             EX_MEM_MemWrite_i,
    input  logic             mem_stall_i,
    input  logic             mem_ack_i,
    input  logic             Branch_taken_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Flush_o,
    output logic             Freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    state_e state_q;
    state_e state_d;
    logic   mem_miss;
    logic   load_use;
    logic   freeze;

    assign mem_miss = (EX_MEM_MemRead_i | EX_MEM_MemWrite_i) & mem_stall_i;

    // x0 is hard-wired zero, so a load targeting it never creates a hazard.
    assign load_use = ID_EX_MemRead_i && (ID_EX_RDaddr_i != 5'd0) &&
                      ((ID_EX_RDaddr_i == IF_ID_RS1addr_i) ||
                       (ID_EX_RDaddr_i == IF_ID_RS2addr_i));

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path
        // leaves one unassigned and no latch is inferred.
        state_d = state_q;
        freeze  = 1'b0;
        case (state_q)
            // The miss cycle itself freezes immediately; the wait starts at the edge.
            RUN: begin
                if (mem_miss) begin
                    freeze  = 1'b1;
                    state_d = MEM_WAIT;
                end
            end
            // Frozen through the ack cycle; mem_stall_i is irrelevant here.
            MEM_WAIT: begin
                freeze = 1'b1;
                if (mem_ack_i) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        PCWrite_o     = 1'b1;
        IF_ID_Write_o = 1'b1;
        IF_ID_Flush_o = 1'b0;
        ID_EX_Flush_o = 1'b0;
        Freeze_o      = freeze;
        if (freeze) begin
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
        end else if (load_use) begin
            // A branch in ID is ignored here: its operands are not yet valid.
            PCWrite_o     = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
        end else if (Branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (freeze | load_use),
        .cnt_o (stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (IF_ID_Flush_o),
        .cnt_o (flush_cnt_o)
    );

endmodule : hazard_stall_ctrl
